// File: rtl/imem_loader.sv
// Byte-stream program loader: writes instruction memory words and holds the CPU in reset until loaded.
// Optional checksum byte after the payload is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          MEM_SIZE   = 4096,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [31:0]           wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0]           MAX_WORDS = 17'(MEM_SIZE / 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [15:0] len_full;
  logic [1:0]  lane;
  logic [23:0] asm_buf;
  logic [15:0] word_idx;
  logic        xfer;
  logic        last_byte;
  logic        reload_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  assign xfer      = in_valid && in_ready;
  assign len_full  = {in_data, len_lo};
  assign last_byte = (lane == 2'd3) && (word_idx == len - 16'd1);
  assign reload_ok = reload && ((state == S_DONE) || (state == S_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    error    = 1'b0;
    case (state)
      S_IDLE:  state_nx = S_LEN0;
      S_LEN0: begin
        in_ready = 1'b1;
        if (xfer) state_nx = S_LEN1;
      end
      S_LEN1: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_WORDS) state_nx = S_ERR;
          else                                                   state_nx = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer && last_byte) state_nx = S_CHK;
`else
        if (xfer && last_byte) state_nx = S_FLUSH;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (xfer) state_nx = (in_data == sum) ? S_DONE : S_ERR;
      end
`endif
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  if (reload) state_nx = S_LEN0;
      S_ERR: begin
        error = 1'b1;
        if (reload) state_nx = S_LEN0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // done/cpu_hold are registered off the state, so they trail DONE entry by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo   <= '0;
      len      <= '0;
      lane     <= '0;
      asm_buf  <= '0;
      word_idx <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      we       <= 1'b0;
      done     <= (state == S_DONE) && !reload;
      cpu_hold <= !((state == S_DONE) && !reload);
      if (state == S_LEN0 && xfer) len_lo <= in_data;
      if (state == S_LEN1 && xfer) len    <= len_full;
      if (state == S_DATA && xfer) begin
        lane <= lane + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum  <= sum + in_data;
`endif
        case (lane)
          2'd0: asm_buf[7:0]   <= in_data;
          2'd1: asm_buf[15:8]  <= in_data;
          2'd2: asm_buf[23:16] <= in_data;
          default: begin
            we       <= 1'b1;
            wdata    <= {in_data, asm_buf};
            waddr    <= BASE + ADDR_WIDTH'({word_idx, 2'b00});
            word_idx <= word_idx + 16'd1;
          end
        endcase
      end
      if (reload_ok) begin
        word_idx <= '0;
        lane     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of frames plus hand-written timing/reset sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        reload = 1'b0;
  logic        in_ready, we, cpu_hold, done, error;
  logic [31:0] waddr, wdata;

  imem_loader #(.ADDR_WIDTH(32), .MEM_SIZE(4096), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .reload(reload), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   off;
    int   n;
    int   gap;
    logic exp_done;
    logic exp_err;
    int   exp_writes;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_writes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [7:0]  pool[$];
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      n_writes++;
      if (exp_q.size() == 0) chk("spurious_we", 64'(we), 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("write_addr_data", {waddr, wdata}, mon_e);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cyc;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 40) begin @(negedge clk); cyc++; end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_in_ready", 64'(in_ready), 64'd1);
    chk("reload_error",    64'(error),    64'd0);
    chk("reload_done",     64'(done),     64'd0);
    chk("reload_cpu_hold", 64'(cpu_hold), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int          wr0, idx, k, cyc;
    logic [31:0] w;
    logic [7:0]  sum;
    wr0 = n_writes; idx = 0; sum = 8'h00; w = '0;
    for (int i = 0; i < v.n; i++) begin
      if (i >= 2) begin
        k = (i - 2) % 4;
        w[8*k +: 8] = pool[v.off+i];
        sum = sum + pool[v.off+i];
        if (k == 3) begin
          exp_q.push_back({32'(4 * idx), w});
          idx++;
        end
      end
      send_byte(pool[v.off+i], (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.exp_done) send_byte(sum, 0);
`endif
    cyc = 0;
    @(negedge clk);
    while (!(done || error) && cyc < 20) begin @(negedge clk); cyc++; end
    chk("vec_done",     64'(done),     64'(v.exp_done));
    chk("vec_error",    64'(error),    64'(v.exp_err));
    chk("vec_cpu_hold", 64'(cpu_hold), 64'(!v.exp_done));
    chk("vec_in_ready", 64'(in_ready), 64'd0);
    chk("vec_writes",   64'(n_writes - wr0), 64'(v.exp_writes));
    chk("vec_pending",  64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    pool = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
             8'h00, 8'h00,
             8'h01, 8'h04,
             8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
             8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC,
             8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[0] = '{0,  10, 0, 1'b1, 1'b0, 2};
    vecs[1] = '{10, 2,  0, 1'b0, 1'b1, 0};
    vecs[2] = '{12, 2,  0, 1'b0, 1'b1, 0};
    vecs[3] = '{0,  10, 5, 1'b1, 1'b0, 2};
    vecs[4] = '{14, 6,  0, 1'b1, 1'b0, 1};
    vecs[5] = '{20, 14, 2, 1'b1, 1'b0, 3};
    vecs[6] = '{34, 6,  0, 1'b1, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_we",       64'(we),       64'd0);
    chk("rst_waddr",    64'(waddr),    64'd0);
    chk("rst_wdata",    64'(wdata),    64'd0);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_error",    64'(error),    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      do_reload();
    end

    // Exact completion timing, with a reload pulse mid-frame that must be ignored.
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    @(negedge clk);
    chk("tim_we_pulse", 64'(we), 64'd1);
    chk("tim_done_t0",  64'(done), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("tim_chk_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send_byte(8'h0E, 0);
    @(negedge clk);
    chk("tim_done_t1", 64'(done), 64'd0);
`else
    chk("tim_flush_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("tim_done_t1", 64'(done), 64'd0);
    chk("tim_we_once", 64'(we),   64'd0);
`endif
    @(negedge clk);
    chk("tim_done_t2",     64'(done),     64'd1);
    chk("tim_cpu_hold_t2", 64'(cpu_hold), 64'd0);
    chk("tim_pending",     64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    do_reload();

    // Reset in the middle of a word discards it.
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_wdata",    64'(wdata),    64'd0);
    chk("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[6]);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reload();
    begin
      int wr0;
      wr0 = n_writes;
      exp_q.push_back({32'h0, 32'h04030201});
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(8'h0B, 0);
      @(negedge clk);
      chk("badsum_error",    64'(error),    64'd1);
      chk("badsum_cpu_hold", 64'(cpu_hold), 64'd1);
      chk("badsum_writes",   64'(n_writes - wr0), 64'd1);
      chk("badsum_pending",  64'(exp_q.size()), 64'd0);
    end
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes the instruction memory from a byte stream. It sits between a byte source (UART receiver or testbench) and the instruction memory's write port, and holds the CPU in reset until a complete image has been written. Bytes are packed little-endian: the lowest-addressed byte is the least significant byte of the word, which is the order the fetch path reads.

## Interface
- ADDR_WIDTH, 32, width of the write address.
- MEM_SIZE, 4096, instruction memory size in bytes; the maximum image is MEM_SIZE/4 words.
- BASE_ADDR, 0, byte address of the first word written.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs on an edge where in_valid and in_ready are both 1.
- reload  input  1  restarts loading; only honoured in DONE or ERR.
- we  output  1  one-cycle word write strobe.
- waddr  output  ADDR_WIDTH  byte address of the word, always 4-aligned.
- wdata  output  32  word to write.
- cpu_hold  output  1  holds the CPU in reset while 1.
- done  output  1  image loaded successfully.
- error  output  1  load aborted.

## Operation
- Frame format: word count N as 2 bytes (LE, 16-bit), then 4N payload bytes, then 1 checksum byte (only when checksum is compiled in).
- States: IDLE, LEN0, LEN1, DATA, CHK, FLUSH, DONE, ERR.
- IDLE is the reset state. It moves to LEN0 unconditionally on the first edge after rst_n deasserts.
- in_ready is 1 in LEN0, LEN1, DATA and CHK, and 0 in all other states. It is decoded from the state.
- LEN0 captures N[7:0]. LEN1 captures N[15:8].
- After LEN1, the loader goes to ERR if N==0 or N>MEM_SIZE/4; otherwise it goes to DATA.
- DATA uses a 2-bit byte-lane counter k: the accepted byte goes to bits [8k+7:8k] of the assembly register.
- When the 4th byte of a word is accepted, we=1 for the next cycle, with waddr=BASE_ADDR+4*word_idx and the assembled wdata. word_idx then increments.
- The memory never back-pressures the loader, so a write strobe never overlaps the next word's completion.
- After the last payload byte, the loader goes to FLUSH (or to CHK when checksum is compiled in). FLUSH lasts one cycle, then the loader goes to DONE.
- DONE: done=1, cpu_hold=0.
- ERR: error=1, cpu_hold=1.
- reload=1 in DONE or ERR goes to LEN0 on the next edge and clears done, error, word_idx, the lane counter and the checksum. cpu_hold=1 from that edge. reload is ignored in every other state.
- Reset during any state discards a partial word or image and returns all outputs to their reset values.

## Timing
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, error=0.
- Byte acceptance takes 0 wait states; the loader can accept one byte every cycle.
- Write latency: the 4th byte of a word is accepted at edge t, so we is high in the cycle between edge t and edge t+1.
- Without checksum: the last byte is accepted at edge t, FLUSH occupies the cycle after t, and done=1 / cpu_hold=0 from edge t+2.
- ERR after the length check is entered on the edge that accepts the second length byte.
- in_valid may drop at any byte boundary; the loader holds all state while no transfer occurs.
- we, waddr and wdata are registered. waddr and wdata hold their values after the strobe until the next write.

## Configuration
- IMEM_LOADER_CHECKSUM_EN, when defined:
  - The loader keeps an 8-bit modulo-256 sum of all payload bytes.
  - After the last payload byte it goes to CHK, where the final word's we pulse still occurs.
  - Accepting a checksum byte equal to the sum goes to DONE on that edge; a mismatch goes to ERR.
  - Words already written are not retracted.
- Not defined: the CHK state and the sum logic are absent; the path is DATA -> FLUSH -> DONE.

## Test plan
- Stream 02 00 13 05 10 00 93 05 20 00 at full rate -> exactly two write strobes: waddr 0x0 with wdata 0x00100513, then waddr 0x4 with wdata 0x00200593. done=1 and cpu_hold=0 two cycles after the last byte.
- Stream 00 00 -> error=1, in_ready=0, cpu_hold=1, no we. Then reload=1 -> LEN0, error=0, in_ready=1.
- Stream 01 04 (N=1025 with MEM_SIZE=4096) -> ERR, no we.
- Same stream as the first scenario with random in_valid gaps of 0-5 cycles -> identical writes and the same final state.
- Assert rst_n=0 after 2 payload bytes, then reload 01 00 EF BE AD DE -> no write from the aborted word. Then a single write: waddr 0x0, wdata 0xDEADBEEF.
- With IMEM_LOADER_CHECKSUM_EN: 01 00 01 02 03 04 0A -> done=1. The same frame with trailing 0B -> error=1 and cpu_hold=1, with the word 0x04030201 already written.
